// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Brief    : Shared phase encodings, lamp constants, default phase durations
//             and the Moore lamp decode for the traffic light controller.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

  localparam int PHASE_W = 3;

  // Phase encodings; 3'd7 is unused and recovers through ALL_R2.
  localparam logic [PHASE_W-1:0] MAIN_G   = 3'd0;
  localparam logic [PHASE_W-1:0] MAIN_Y   = 3'd1;
  localparam logic [PHASE_W-1:0] ALL_R1   = 3'd2;
  localparam logic [PHASE_W-1:0] SIDE_G   = 3'd3;
  localparam logic [PHASE_W-1:0] SIDE_Y   = 3'd4;
  localparam logic [PHASE_W-1:0] ALL_R2   = 3'd5;
  localparam logic [PHASE_W-1:0] PED_WALK = 3'd6;

  // Lamp codes, {R,Y,G} one-hot.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Default phase durations in ticks.
  localparam int DEF_MAIN_GREEN = 20;
  localparam int DEF_SIDE_GREEN = 10;
  localparam int DEF_YELLOW     = 3;
  localparam int DEF_ALL_RED    = 2;
  localparam int DEF_WALK       = 8;

  typedef struct packed {
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
  } lamps_t;

  // Lamp pattern for each phase; anything unrecognised shows red both ways.
  function automatic lamps_t decode_lamps(input logic [PHASE_W-1:0] ph);
    lamps_t l;
    l.main_light = LIGHT_RED;
    l.side_light = LIGHT_RED;
    l.walk       = 1'b0;
    case (ph)
      MAIN_G:   l.main_light = LIGHT_GREEN;
      MAIN_Y:   l.main_light = LIGHT_YELLOW;
      SIDE_G:   l.side_light = LIGHT_GREEN;
      SIDE_Y:   l.side_light = LIGHT_YELLOW;
      PED_WALK: l.walk       = 1'b1;
      default:  ;
    endcase
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Brief    : 8-bit loadable down-counter that steps on tick and parks at 0.
//  Revision : 1.0  initial release
// ============================================================================
module phase_timer #(
  parameter logic [7:0] RESET_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick_en,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] r_count;

  // A load beats a tick; otherwise decrement on tick until the count hits 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= RESET_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick_en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_ctrl
//  Brief    : Two-road intersection controller with demand-driven side phase
//             and a pedestrian walk phase that takes priority over side road.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN = DEF_MAIN_GREEN,
  parameter int SIDE_GREEN = DEF_SIDE_GREEN,
  parameter int YELLOW     = DEF_YELLOW,
  parameter int ALL_RED    = DEF_ALL_RED,
  parameter int WALK       = DEF_WALK
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         side_req,
  input  logic         ped_req,
  output logic [2:0]   main_light,
  output logic [2:0]   side_light,
  output logic         walk,
  output logic         ped_wait,
  output logic [7:0]   remaining,
  output logic [2:0]   phase
);

  // Counter load values are duration minus one so each phase lasts N ticks.
  localparam logic [7:0] c_MAIN_LOAD = 8'(MAIN_GREEN - 1);
  localparam logic [7:0] c_SIDE_LOAD = 8'(SIDE_GREEN - 1);
  localparam logic [7:0] c_YEL_LOAD  = 8'(YELLOW - 1);
  localparam logic [7:0] c_RED_LOAD  = 8'(ALL_RED - 1);
  localparam logic [7:0] c_WALK_LOAD = 8'(WALK - 1);

  logic [PHASE_W-1:0] r_phase;
  logic               r_ped_wait;
  logic [PHASE_W-1:0] w_next_phase;
  logic               w_load;
  logic [7:0]         w_load_val;
  logic [7:0]         w_count;
  logic               w_zero;
  logic               w_expire;
  lamps_t             w_lamps;

  assign w_expire = tick & w_zero;

  // Next-phase selection; phases advance only when the countdown expires on a
  // tick, except an illegal encoding which recovers at once.
  always_comb begin
    w_next_phase = r_phase;
    case (r_phase)
      MAIN_G:   if (w_expire && (side_req || r_ped_wait)) w_next_phase = MAIN_Y;
      MAIN_Y:   if (w_expire) w_next_phase = ALL_R1;
      ALL_R1:   if (w_expire) w_next_phase = r_ped_wait ? PED_WALK : SIDE_G;
      SIDE_G:   if (w_expire) w_next_phase = SIDE_Y;
      SIDE_Y:   if (w_expire) w_next_phase = ALL_R2;
      PED_WALK: if (w_expire) w_next_phase = ALL_R2;
      ALL_R2:   if (w_expire) w_next_phase = MAIN_G;
      default:  w_next_phase = ALL_R2;
    endcase
  end

  // Reload the countdown with the new phase's duration on every phase change;
  // a main-green hold without demand never reloads, so remaining sits at 0.
  always_comb begin
    w_load     = (w_next_phase != r_phase);
    w_load_val = c_RED_LOAD;
    case (w_next_phase)
      MAIN_G:   w_load_val = c_MAIN_LOAD;
      MAIN_Y:   w_load_val = c_YEL_LOAD;
      SIDE_Y:   w_load_val = c_YEL_LOAD;
      SIDE_G:   w_load_val = c_SIDE_LOAD;
      PED_WALK: w_load_val = c_WALK_LOAD;
      default:  w_load_val = c_RED_LOAD;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= MAIN_G;
    end else begin
      r_phase <= w_next_phase;
    end
  end

  // Pedestrian request latch: entering the walk phase clears it even if the
  // button is pressed on that same edge; presses during the walk are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ped_wait <= 1'b0;
    end else if ((w_next_phase == PED_WALK) && (r_phase != PED_WALK)) begin
      r_ped_wait <= 1'b0;
    end else if (ped_req && (r_phase != PED_WALK)) begin
      r_ped_wait <= 1'b1;
    end
  end

  phase_timer #(
    .RESET_VAL (c_MAIN_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick_en  (tick),
    .count    (w_count),
    .zero     (w_zero)
  );

  // Moore lamp decode straight from the phase register.
  always_comb begin
    w_lamps = decode_lamps(r_phase);
  end

  assign main_light = w_lamps.main_light;
  assign side_light = w_lamps.side_light;
  assign walk       = w_lamps.walk;
  assign ped_wait   = r_ped_wait;
  assign remaining  = w_count;
  assign phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_ctrl
//  Brief    : Directed scoreboard bench for traffic_light_ctrl (defaults).
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_wait;
  logic [7:0] remaining;
  logic [2:0] phase;

  traffic_light_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .ped_wait   (ped_wait),
    .remaining  (remaining),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         scen;
    logic [2:0] ph;
    logic [7:0] rem;
    logic       pw;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tcount      = 0;
  bit   started     = 1'b0;

  // Lamp table for each phase.
  function automatic logic [2:0] exp_main(input logic [2:0] ph);
    if (ph == MAIN_G) return 3'b001;
    if (ph == MAIN_Y) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input logic [2:0] ph);
    if (ph == SIDE_G) return 3'b001;
    if (ph == SIDE_Y) return 3'b010;
    return 3'b100;
  endfunction

  task automatic check_now(input int scen, input int at, input logic [2:0] ph,
                           input logic [7:0] rem, input logic pw);
    logic [2:0] em;
    logic [2:0] es;
    logic       ew;
    em = exp_main(ph);
    es = exp_side(ph);
    ew = (ph == PED_WALK);
    vectors++;
    if (phase !== ph || remaining !== rem || main_light !== em ||
        side_light !== es || walk !== ew || ped_wait !== pw) begin
      miscompares++;
      $display("FAIL s%0d tick%0d: got phase=%0d rem=%0d main=%b side=%b walk=%b ped_wait=%b, want phase=%0d rem=%0d main=%b side=%b walk=%b ped_wait=%b",
               scen, at, phase, remaining, main_light, side_light, walk, ped_wait,
               ph, rem, em, es, ew, pw);
    end
  endtask

  task automatic push(input int scen, input int at, input logic [2:0] ph,
                      input logic [7:0] rem, input logic pw);
    exp_t x;
    x.at   = at;
    x.scen = scen;
    x.ph   = ph;
    x.rem  = rem;
    x.pw   = pw;
    sbq.push_back(x);
  endtask

  // Monitor: counts ticks seen by the DUT and checks queued expectations
  // for that tick shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    if (!reset && tick) begin
      tcount++;
      #1;
      while (sbq.size() > 0 && sbq[0].at <= tcount) begin
        e = sbq.pop_front();
        if (e.at < tcount) begin
          vectors++;
          miscompares++;
          $display("FAIL s%0d tick%0d: expectation skipped, tick count already %0d",
                   e.scen, e.at, tcount);
        end else begin
          check_now(e.scen, e.at, e.ph, e.rem, e.pw);
        end
      end
    end
  end

  // Lamp invariant every cycle: one-hot, and never both roads non-red.
  always @(negedge clk) begin
    if (started) begin
      if (!$onehot(main_light) || !$onehot(side_light) ||
          (main_light != LIGHT_RED && side_light != LIGHT_RED)) begin
        miscompares++;
        $display("FAIL lamp_invariant: main=%b side=%b, want one-hot with a red road",
                 main_light, side_light);
      end
    end
  end

  task automatic do_reset(input int scen);
    @(negedge clk);
    reset    = 1'b1;
    tick     = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    @(negedge clk);
    tcount = 0;
    started = 1'b1;
    check_now(scen, 0, MAIN_G, 8'd19, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic tick_with_ped();
    @(negedge clk);
    tick    = 1'b1;
    ped_req = 1'b1;
    @(negedge clk);
    tick    = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic ped_pulse();
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
  endtask

  task automatic drain(input int scen);
    int budget;
    exp_t e;
    budget = 20;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL s%0d tick%0d: expectation never reached (ticks seen %0d)",
               e.scen, e.at, tcount);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Scenario 1: no demand, main green parks at remaining 0.
    do_reset(1);
    push(1, 1,   MAIN_G, 8'd18, 1'b0);
    push(1, 19,  MAIN_G, 8'd0,  1'b0);
    push(1, 20,  MAIN_G, 8'd0,  1'b0);
    push(1, 100, MAIN_G, 8'd0,  1'b0);
    ticks(10);
    repeat (7) @(negedge clk);
    check_now(1, 10, MAIN_G, 8'd9, 1'b0);
    ticks(90);
    drain(1);

    // Scenario 2: side demand held, full side cycle back to main green.
    do_reset(2);
    side_req = 1'b1;
    push(2, 19, MAIN_G, 8'd0, 1'b0);
    push(2, 20, MAIN_Y, 8'd2, 1'b0);
    push(2, 22, MAIN_Y, 8'd0, 1'b0);
    push(2, 23, ALL_R1, 8'd1, 1'b0);
    push(2, 25, SIDE_G, 8'd9, 1'b0);
    push(2, 34, SIDE_G, 8'd0, 1'b0);
    push(2, 35, SIDE_Y, 8'd2, 1'b0);
    push(2, 38, ALL_R2, 8'd1, 1'b0);
    push(2, 40, MAIN_G, 8'd19, 1'b0);
    ticks(40);
    drain(2);

    // Scenario 3: single pedestrian pulse, press on the walk-entry edge and
    // a press during the walk are both dropped.
    do_reset(3);
    push(3, 5,  MAIN_G,   8'd14, 1'b0);
    push(3, 6,  MAIN_G,   8'd13, 1'b1);
    push(3, 20, MAIN_Y,   8'd2,  1'b1);
    push(3, 24, ALL_R1,   8'd0,  1'b1);
    push(3, 25, PED_WALK, 8'd7,  1'b0);
    push(3, 28, PED_WALK, 8'd4,  1'b0);
    push(3, 32, PED_WALK, 8'd0,  1'b0);
    push(3, 33, ALL_R2,   8'd1,  1'b0);
    push(3, 35, MAIN_G,   8'd19, 1'b0);
    ticks(5);
    ped_pulse();
    ticks(19);
    tick_with_ped();
    ticks(2);
    ped_pulse();
    ticks(8);
    drain(3);

    // Scenario 4: pedestrian and side demand together, walk served first.
    do_reset(4);
    side_req = 1'b1;
    ped_pulse();
    push(4, 1,  MAIN_G,   8'd18, 1'b1);
    push(4, 20, MAIN_Y,   8'd2,  1'b1);
    push(4, 25, PED_WALK, 8'd7,  1'b0);
    push(4, 33, ALL_R2,   8'd1,  1'b0);
    push(4, 35, MAIN_G,   8'd19, 1'b0);
    push(4, 55, MAIN_Y,   8'd2,  1'b0);
    push(4, 58, ALL_R1,   8'd1,  1'b0);
    push(4, 60, SIDE_G,   8'd9,  1'b0);
    ticks(60);
    drain(4);

    // Scenario 5: no ticks for 1000 cycles in side green, then async reset.
    repeat (1000) @(negedge clk);
    check_now(5, 60, SIDE_G, 8'd9, 1'b0);
    push(5, 62, SIDE_G, 8'd7, 1'b0);
    ticks(2);
    drain(5);
    ped_pulse();
    check_now(5, 62, SIDE_G, 8'd7, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_now(5, 0, MAIN_G, 8'd19, 1'b0);
    @(negedge clk);
    tcount = 0;
    reset = 1'b0;
    push(5, 1, MAIN_G, 8'd18, 1'b0);
    ticks(1);
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
